// File: rtl/tag_raw_readout.sv
// tag_raw_readout: reads entries 0..nevt-1 from the tag raw-event RAM and
// streams the lower 128 bits of each entry as four 32-bit words. Every frame
// is a header, the payload and a trailer that carries a folded XOR checksum.
//
// Stream handshake: a beat moves on a rising clk edge where dout_valid and
// dout_ready are both high. Once dout_valid is raised, dout, dout_valid and
// dout_last are held unchanged until that beat moves; valid is never dropped
// before the transfer.
module tag_raw_readout #(
    parameter int          AW      = 11,
    parameter int          RD_LAT  = 1,
    parameter logic [15:0] HDR_TAG = 16'hEEEE,
    parameter logic [15:0] TRL_TAG = 16'hFFFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [11:0]   nevt,
    output logic [AW-1:0] raw_raddr,
    output logic          raw_rena,
    input  logic [255:0]  raw_rdata,
    output logic [31:0]   dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last,
    output logic          busy,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_FETCH   = 3'd2,
        S_WAIT    = 3'd3,
        S_SEND    = 3'd4,
        S_TRAILER = 3'd5
    } state_t;

    state_t          r_state;
    logic [11:0]     r_nevt;
    logic [11:0]     r_cnt;
    logic [1:0]      r_idx;
    logic [1:0]      r_wcnt;
    logic [31:0]     r_csum;
    logic [127:0]    r_hold;
    logic [AW-1:0]   r_raddr;
    logic            r_rena;
    logic [31:0]     r_dout;
    logic            r_valid;
    logic            r_last;
    logic            r_busy;

    logic [11:0]     w_nevt_clamp;
    logic            w_xfer;
    logic [31:0]     w_csum_nx;
    logic [11:0]     w_cnt_nx;
    logic [1:0]      w_idx_nx;
    logic [31:0]     w_word_nx;
    logic [31:0]     w_trl_send;
    logic [31:0]     w_trl_empty;
    logic            w_unused_hi;

    // Requests above the RAM depth are clamped to a full-RAM readout.
    assign w_nevt_clamp = (nevt > 12'd2048) ? 12'd2048 : nevt;
    assign w_xfer       = r_valid & dout_ready;
    // Checksum including the beat that is moving this cycle.
    assign w_csum_nx    = r_csum ^ r_dout;
    assign w_cnt_nx     = r_cnt + 12'd1;
    assign w_idx_nx     = r_idx + 2'd1;
    assign w_word_nx    = r_hold[{w_idx_nx, 5'd0} +: 32];
    assign w_trl_send   = {TRL_TAG, w_csum_nx[31:16] ^ w_csum_nx[15:0]};
    assign w_trl_empty  = {TRL_TAG, r_csum[31:16] ^ r_csum[15:0]};
    // Upper half of each RAM entry is not part of the readout.
    assign w_unused_hi  = ^raw_rdata[255:128];

    assign raw_raddr  = r_raddr;
    assign raw_rena   = r_rena;
    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign dout_last  = r_last;
    assign busy       = r_busy;
    assign dbg_state  = r_state;

    // Readout sequencer; all outputs are registered and loaded on state entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_nevt  <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wcnt  <= '0;
            r_csum  <= '0;
            r_hold  <= '0;
            r_raddr <= '0;
            r_rena  <= 1'b0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_nevt  <= w_nevt_clamp;
                        r_cnt   <= '0;
                        r_csum  <= '0;
                        r_dout  <= {HDR_TAG, 4'h0, w_nevt_clamp};
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (w_xfer) begin
                        if (r_nevt == 12'd0) begin
                            r_dout  <= w_trl_empty;
                            r_last  <= 1'b1;
                            r_state <= S_TRAILER;
                        end else begin
                            r_valid <= 1'b0;
                            r_dout  <= '0;
                            r_raddr <= r_cnt[AW-1:0];
                            r_rena  <= 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    r_rena  <= 1'b0;
                    r_wcnt  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wcnt == 2'(RD_LAT - 1)) begin
                        r_hold  <= raw_rdata[127:0];
                        r_idx   <= '0;
                        r_dout  <= raw_rdata[31:0];
                        r_valid <= 1'b1;
                        r_state <= S_SEND;
                    end else begin
                        r_wcnt <= r_wcnt + 2'd1;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        r_csum <= w_csum_nx;
                        r_idx  <= w_idx_nx;
                        if (r_idx == 2'd3) begin
                            r_cnt <= w_cnt_nx;
                            if (w_cnt_nx == r_nevt) begin
                                r_dout  <= w_trl_send;
                                r_last  <= 1'b1;
                                r_state <= S_TRAILER;
                            end else begin
                                r_valid <= 1'b0;
                                r_dout  <= '0;
                                r_raddr <= w_cnt_nx[AW-1:0];
                                r_rena  <= 1'b1;
                                r_state <= S_FETCH;
                            end
                        end else begin
                            r_dout <= w_word_nx;
                        end
                    end
                end
                S_TRAILER: begin
                    if (w_xfer) begin
                        r_dout  <= '0;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tag_raw_readout.sv
// Bench for tag_raw_readout: RAM model with one-clock read latency, a
// scoreboard of expected beats and read addresses, and directed frames.
module tb_tag_raw_readout;

  localparam int T = 10;
  localparam int W = 33;  // {last, data}

  logic         clk;
  logic         rst;
  logic         start;
  logic [11:0]  nevt;
  logic [10:0]  raw_raddr;
  logic         raw_rena;
  logic [255:0] raw_rdata;
  logic [31:0]  dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_last;
  logic         busy;
  logic [2:0]   dbg_state;

  logic [255:0] mem [0:2047];
  logic [W-1:0] exp_q[$];
  logic [10:0]  addr_q[$];

  int  n_tests = 0;
  int  n_fail  = 0;
  int  rdy_mode = 0;
  int  rena_cnt = 0;
  int  beats = 0;
  int  n_extra = 0;
  int  n_extra_rd = 0;
  bit  stall_prev = 0;
  logic [W-1:0] prev_beat;
  time t0;
  time t_trl;

  tag_raw_readout dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .nevt       (nevt),
    .raw_raddr  (raw_raddr),
    .raw_rena   (raw_rena),
    .raw_rdata  (raw_rdata),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #(T/2) clk = ~clk;
  end

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // RAM model, one clock read latency
  always @(posedge clk) begin
    if (raw_rena) raw_rdata <= mem[raw_raddr];
  end

  // ready driver: 0 = always high, 1 = toggle, 2 = random
  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        1:       dout_ready = ~dout_ready;
        2:       dout_ready = 1'($urandom_range(0, 1));
        default: dout_ready = 1'b1;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (raw_rena) begin
        rena_cnt++;
        if (addr_q.size() == 0) n_extra_rd++;
        else chk("raddr", 64'(raw_raddr), 64'(addr_q.pop_front()));
      end
      if (stall_prev) begin
        chk("hold_valid", 64'(dout_valid), 64'd1);
        chk("hold_beat", 64'({dout_last, dout}), 64'(prev_beat));
      end
      if (dout_valid && dout_ready) begin
        beats++;
        if (exp_q.size() == 0) n_extra++;
        else chk("beat", 64'({dout_last, dout}), 64'(exp_q.pop_front()));
        if (dout_last) t_trl = $time + T/2;
      end
      stall_prev = dout_valid && !dout_ready;
      prev_beat  = {dout_last, dout};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic push_frame(input int n);
    int          nc;
    logic [31:0] cs;
    logic [31:0] wd;
    logic [255:0] ent;
    nc = (n > 2048) ? 2048 : n;
    cs = '0;
    exp_q.push_back({1'b0, 16'hEEEE, 4'h0, 12'(nc)});
    for (int e = 0; e < nc; e++) begin
      addr_q.push_back(11'(e));
      ent = mem[e];
      for (int w = 0; w < 4; w++) begin
        wd = ent[32*w +: 32];
        exp_q.push_back({1'b0, wd});
        cs = cs ^ wd;
      end
    end
    exp_q.push_back({1'b1, 16'hFFFF, cs[31:16] ^ cs[15:0]});
  endtask

  task automatic do_start(input int n);
    @(posedge clk);
    #1;
    start = 1'b1;
    nevt  = 12'(n);
    beats = 0;
    @(posedge clk);
    t0 = $time;
    #1;
    start = 1'b0;
    nevt  = 12'h5A5;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_timeout", 64'(ok), 64'd1);
    chk("drain_beats", 64'(exp_q.size()), 64'd0);
    chk("drain_addrs", 64'(addr_q.size()), 64'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_dout"},  64'(dout), 64'd0);
    chk({tag, "_valid"}, 64'(dout_valid), 64'd0);
    chk({tag, "_last"},  64'(dout_last), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_rena"},  64'(raw_rena), 64'd0);
    chk({tag, "_raddr"}, 64'(raw_raddr), 64'd0);
  endtask

  initial begin
    int  rb;
    bit  found;
    rst   = 1'b0;
    start = 1'b0;
    nevt  = '0;
    for (int i = 0; i < 2048; i++)
      mem[i] = {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    mem[0][127:0] = 128'h00000004_00000003_00000002_00000001;
    mem[1][127:0] = 128'h00000008_00000007_00000006_00000005;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b1;

    // empty frame
    rb = rena_cnt;
    push_frame(0);
    do_start(0);
    wait_done(100);
    chk("empty_beats", 64'(beats), 64'd2);
    chk("empty_rena", 64'(rena_cnt - rb), 64'd0);

    // two entries, ready high, latency
    rb = rena_cnt;
    push_frame(2);
    do_start(2);
    wait_done(200);
    chk("two_beats", 64'(beats), 64'd10);
    chk("two_rena", 64'(rena_cnt - rb), 64'd2);
    chk("two_cycles", 64'((t_trl - t0) / T), 64'd14);

    // two entries, ready toggling
    rdy_mode = 1;
    rb = rena_cnt;
    push_frame(2);
    do_start(2);
    wait_done(400);
    chk("tog_beats", 64'(beats), 64'd10);
    chk("tog_rena", 64'(rena_cnt - rb), 64'd2);
    rdy_mode = 0;

    // oversized request clamps to the full RAM
    rb = rena_cnt;
    push_frame(4095);
    do_start(4095);
    wait_done(20000);
    chk("full_beats", 64'(beats), 64'd8194);
    chk("full_rena", 64'(rena_cnt - rb), 64'd2048);
    chk("full_busy", 64'(busy), 64'd0);

    // reset while sending entry 5
    push_frame(8);
    do_start(8);
    found = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (raw_rena && raw_raddr == 11'd5) begin
        found = 1'b1;
        break;
      end
    end
    chk("find_entry5", 64'(found), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 64'(dout_valid), 64'd1);
    rst = 1'b0;
    #1;
    check_zero_outputs("midrst");
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    rb = rena_cnt;
    push_frame(1);
    do_start(1);
    wait_done(200);
    chk("after_rst_beats", 64'(beats), 64'd6);
    chk("after_rst_rena", 64'(rena_cnt - rb), 64'd1);

    // start while busy is ignored
    rdy_mode = 2;
    push_frame(3);
    do_start(3);
    repeat (6) @(posedge clk);
    #1;
    start = 1'b1;
    nevt  = 12'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1000);
    rdy_mode = 0;
    repeat (20) @(posedge clk);
    chk("busy_start_beats", 64'(beats), 64'd14);
    chk("extra_beats", 64'(n_extra), 64'd0);
    chk("extra_reads", 64'(n_extra_rd), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
